cla_seq_adder: RTL and testbench

CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

---
 rtl/cla_seq_adder.sv | 191 +++++++++++++++++++
 tb/tb_cla_seq_adder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_adder.sv
// -----------------------------------------------------------------------------
// cla_seq_adder
//   Sequential WIDTH-bit adder built around one 4-bit carry-lookahead adder.
//   It is used once per clock edge, lowest nibble first. An add takes NIB
//   edges after the operands are accepted. Inputs and outputs use a
//   valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands a/b/cin are valid
//   in_ready   block is idle and can accept operands
//   a, b       WIDTH-bit operands (unsigned or two's complement)
//   cin        carry into nibble 0
//   out_valid  sum/cout/ovf hold a finished result
//   out_ready  consumer takes the result
//   sum        registered WIDTH-bit result
//   cout       carry out of the MSB
//   ovf        two's-complement overflow
// -----------------------------------------------------------------------------

// 4-bit carry-lookahead adder: every carry is computed directly from the
// generate/propagate terms instead of rippling through the lower carries.
module cla4 (
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic       c_in,
    output logic [3:0] s4,
    output logic       c_out
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a4 & b4;
    assign p = a4 ^ b4;

    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_in);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c_in);

    assign s4    = p ^ c[3:0];
    assign c_out = c[4];
endmodule

module cla_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = $clog2(NIB);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    // Split the captured operands into nibbles so the current one can be
    // picked with a simple index mux.
    logic [3:0] a_nib [NIB];
    logic [3:0] b_nib [NIB];

    for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
        assign a_nib[gi] = a_q[4*gi +: 4];
        assign b_nib[gi] = b_q[4*gi +: 4];
    end

    logic [3:0] cla_a, cla_b, cla_s;
    logic       cla_c;
    logic       last_nib;

    assign cla_a    = a_nib[idx_q];
    assign cla_b    = b_nib[idx_q];
    assign last_nib = (idx_q == IDX_W'(NIB - 1));

    cla4 u_cla4 (
        .a4    (cla_a),
        .b4    (cla_b),
        .c_in  (carry_q),
        .s4    (cla_s),
        .c_out (cla_c)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                for (int i = 0; i < NIB; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[4*i +: 4] = cla_s;
                    end
                end
                carry_d = cla_c;
                if (last_nib) begin
                    // idx parks at NIB-1; it is cleared again on the next accept.
                    state_d = S_DONE;
                    cout_d  = cla_c;
                    // cla_s[3] is the new sum MSB on the final nibble.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (cla_s[3] != a_q[WIDTH-1]);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_cla_seq_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_seq_adder
//   Self-checking bench for cla_seq_adder (WIDTH=16).
//   - A directed vector table is applied and compared in a loop.
//   - Hand-written sequences cover a stalled consumer and a reset abort.
//   - A random back-to-back run is checked through a scoreboard queue.
//   Handshakes are sampled on the falling edge. Inputs are driven 1 time
//   unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_cla_seq_adder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    cla_seq_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vc;
        logic [15:0] es;
        logic        ec;
        logic        eo;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_acc  = 0;
    int   n_out  = 0;

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic ci);
        exp_t        e;
        logic [16:0] r;
        r   = {1'b0, x} + {1'b0, y} + {16'd0, ci};
        e.s = r[15:0];
        e.c = r[16];
        e.o = (x[15] == y[15]) && (r[15] != x[15]);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // One clock cycle. The handshakes are sampled at the falling edge, which
    // shows what the next rising edge will see. Returns at posedge + 1.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra: got result sum=%h, want no result", sum);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_result", 32'({sum, cout, ovf}), 32'({e.s, e.c, e.o}));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Accept one operand set. Returns the number of edges until out_valid,
    // with a bound of 20 edges.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                          input logic ci, output int lat);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = ci;
        tick();
        in_valid = 1'b0;
        // Scramble the operands so any late sampling would corrupt the result.
        a        = 16'($urandom);
        b        = 16'($urandom);
        cin      = 1'($urandom);
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    vec_t vecs[8];
    int   lat;
    int   cyc;

    initial begin
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;

        // Reset state: check it right away and again after a few clock edges.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_state", 32'({in_ready, out_valid, sum}), 32'({1'b1, 1'b0, 16'h0}));
        rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            chk("pre_in_ready", 32'(in_ready), 32'd1);
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vc, lat);
            $display("vec %0d: %h + %h + %0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
                     i, vecs[i].va, vecs[i].vb, vecs[i].vc, sum, cout, ovf, lat);
            chk("vec_latency", 32'(lat), 32'd4);
            chk("vec_sum", 32'(sum), 32'(vecs[i].es));
            chk("vec_cout", 32'(cout), 32'(vecs[i].ec));
            chk("vec_ovf", 32'(ovf), 32'(vecs[i].eo));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("vec_back_idle", 32'({out_valid, in_ready}), 32'({1'b0, 1'b1}));
        end

        // Consumer stalls in DONE while a new request is presented.
        run_op(16'h1234, 16'h4321, 1'b0, lat);
        chk("stall_latency", 32'(lat), 32'd4);
        in_valid = 1'b1;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        cin      = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_hold", 32'({out_valid, in_ready, sum, cout, ovf}),
                32'({1'b1, 1'b0, 16'h5555, 1'b0, 1'b0}));
        end
        $display("stall: sum=%h held with out_ready=0 for 5 cycles", sum);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("stall_release", 32'({out_valid, in_ready, sum}), 32'({1'b0, 1'b1, 16'h5555}));
        chk("stall_no_queue", 32'(exp_q.size()), 32'd0);

        // Reset aborts an add after the second RUN edge.
        in_valid = 1'b1;
        a        = 16'hAAAA;
        b        = 16'h1111;
        cin      = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_state", 32'({out_valid, in_ready, sum, cout, ovf}),
            32'({1'b0, 1'b1, 16'h0, 1'b0, 1'b0}));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op(16'h0002, 16'h0005, 1'b1, lat);
        $display("post-abort: 0002 + 0005 + 1 -> sum=%h lat=%0d", sum, lat);
        chk("abort_next_latency", 32'(lat), 32'd4);
        chk("abort_next_sum", 32'(sum), 32'h0008);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Random back-to-back traffic checked by the scoreboard.
        n_acc = 0;
        n_out = 0;
        cyc   = 0;
        while ((n_acc < 1000 || exp_q.size() != 0) && cyc < 40000) begin
            in_valid  = (n_acc < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
            a         = 16'($urandom);
            b         = 16'($urandom);
            cin       = 1'($urandom);
            out_ready = 1'($urandom);
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        $display("random: %0d accepted, %0d results in %0d cycles", n_acc, n_out, cyc);
        chk("rand_timeout", 32'(cyc < 40000), 32'd1);
        chk("rand_accepts", 32'(n_acc), 32'd1000);
        chk("rand_results", 32'(n_out), 32'd1000);
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
